// File: rtl/cpu_mem_arb_pkg.sv
// Shared definitions for the CPU memory arbiter.
//   - FSM state encoding (IDLE, ADDR, WAIT)
//   - requester/owner encoding (OWN_INST, OWN_DATA)
//   - access size constants (SZ_BYTE, SZ_HALF, SZ_WORD)
package cpu_mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      WAIT = 2'd2
   } arbState_t;

   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/cpu_mem_arb_sel.sv
// Combinational grant selector for the CPU memory arbiter.
// Ports:
//   inst_req, data_req : pending requests from fetch and load/store
//   last_owner         : requester served most recently (OWN_INST/OWN_DATA)
//   grant_inst         : fetch wins this cycle
//   grant_data         : load/store wins this cycle
// On contention the requester that was not served last wins. Tying
// last_owner to OWN_INST turns this into fixed data-over-inst priority.
module cpu_mem_arb_sel
   import cpu_mem_arb_pkg::*;
(
   input  logic inst_req,
   input  logic data_req,
   input  logic last_owner,
   output logic grant_inst,
   output logic grant_data
);

   assign grant_data = data_req & (~inst_req | (last_owner == OWN_INST));
   assign grant_inst = inst_req & (~data_req | (last_owner == OWN_DATA));

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one sram-like memory port between the MIPS core's instruction
// fetch requester and its data (load/store) requester. One transaction
// is outstanding at a time; the granted request is buffered and replayed
// on the memory port until the memory accepts it.
//
// Handshake: a requester's addr_ok pulses (combinationally, in IDLE) in
// the cycle its req is granted; its data_ok pulses for exactly the cycle
// mem_data_ok completes its transaction, with rdata valid in that cycle
// and held afterwards until the next completion for the same requester.
// mem_req stays high with stable mem_* fields until mem_addr_ok.
//
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   inst_req/inst_addr           : fetch request (word read)
//   inst_addr_ok/data_ok/rdata   : fetch handshakes and read data
//   data_req/wr/size/addr/wdata  : load/store request
//   data_addr_ok/data_ok/rdata   : load/store handshakes and read data
//   mem_req/wr/size/addr/wdata   : downstream request
//   mem_addr_ok/data_ok/rdata    : downstream handshakes and read data
//
// Build option: define CPU_MEM_ARB_RR_EN for round-robin priority on
// contention; otherwise data always wins over inst.
module cpu_mem_arbiter
   import cpu_mem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [1:0]        mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   input  logic [DATA_W-1:0] mem_rdata
);

   arbState_t         stateQ;
   logic              bufOwner;
   logic              bufWr;
   logic [1:0]        bufSize;
   logic [ADDR_W-1:0] bufAddr;
   logic [DATA_W-1:0] bufWdata;
   logic [DATA_W-1:0] instRdataQ;
   logic [DATA_W-1:0] dataRdataQ;
   logic              lastOwner;
   logic              grantInst;
   logic              grantData;
   logic              idleGrant;
   logic              complete;
   logic              instDone;
   logic              dataDone;

   cpu_mem_arb_sel uSel (
      .inst_req   (inst_req),
      .data_req   (data_req),
      .last_owner (lastOwner),
      .grant_inst (grantInst),
      .grant_data (grantData)
   );

   // Handshakes are gated by rst so nothing is acknowledged in a reset cycle.
   assign idleGrant    = (stateQ == IDLE) & ~rst;
   assign inst_addr_ok = idleGrant & grantInst;
   assign data_addr_ok = idleGrant & grantData;

   // Completion: accept+response in the same ADDR cycle, or response in WAIT.
   // mem_data_ok in IDLE (or in ADDR without mem_addr_ok) is ignored.
   assign complete = ~rst & (((stateQ == ADDR) & mem_addr_ok & mem_data_ok) |
                             ((stateQ == WAIT) & mem_data_ok));
   assign instDone = complete & (bufOwner == OWN_INST);
   assign dataDone = complete & (bufOwner == OWN_DATA);

   assign inst_data_ok = instDone;
   assign data_data_ok = dataDone;
   assign inst_rdata   = instDone ? mem_rdata : instRdataQ;
   assign data_rdata   = dataDone ? mem_rdata : dataRdataQ;

   assign mem_req   = (stateQ == ADDR);
   assign mem_wr    = bufWr;
   assign mem_size  = bufSize;
   assign mem_addr  = bufAddr;
   assign mem_wdata = bufWdata;

`ifdef CPU_MEM_ARB_RR_EN
   // Requester served by the most recent grant; breaks ties on contention.
   always_ff @(posedge clk) begin
      if (rst) begin
         lastOwner <= OWN_INST;
      end else if (idleGrant & (grantInst | grantData)) begin
         lastOwner <= grantData ? OWN_DATA : OWN_INST;
      end
   end
`else
   // Constant "inst served last" makes the selector favour data.
   assign lastOwner = OWN_INST;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ     <= IDLE;
         bufOwner   <= OWN_INST;
         bufWr      <= 1'b0;
         bufSize    <= 2'd0;
         bufAddr    <= '0;
         bufWdata   <= '0;
         instRdataQ <= '0;
         dataRdataQ <= '0;
      end else begin
         if (instDone) instRdataQ <= mem_rdata;
         if (dataDone) dataRdataQ <= mem_rdata;

         case (stateQ)
            IDLE: begin
               if (grantData) begin
                  bufOwner <= OWN_DATA;
                  bufWr    <= data_wr;
                  bufSize  <= data_size;
                  bufAddr  <= data_addr;
                  bufWdata <= data_wdata;
                  stateQ   <= ADDR;
               end else if (grantInst) begin
                  // Fetches are always word reads.
                  bufOwner <= OWN_INST;
                  bufWr    <= 1'b0;
                  bufSize  <= SZ_WORD;
                  bufAddr  <= inst_addr;
                  bufWdata <= '0;
                  stateQ   <= ADDR;
               end
            end
            ADDR: begin
               if (mem_addr_ok) stateQ <= mem_data_ok ? IDLE : WAIT;
            end
            WAIT: begin
               if (mem_data_ok) stateQ <= IDLE;
            end
            default: stateQ <= IDLE;
         endcase
      end
   end

endmodule
